// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// state codes, opcodes, funct fields and ALU control values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: fixed add/sub from the FSM, or funct-driven
// operation for R-type execute. Unknown funct falls back to add.
module mc_aludec
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int ACW = 4
) (
  input  aluop_t         aluop,
  input  logic [OPW-1:0] funct,
  output logic [ACW-1:0] alucontrol
);

  always_comb begin
    alucontrol = ACW'(ALU_ADD);
    case (aluop)
      AOP_SUB: alucontrol = ACW'(ALU_SUB);
      AOP_FUNCT: begin
        case (funct)
          F_SUB:   alucontrol = ACW'(ALU_SUB);
          F_AND:   alucontrol = ACW'(ALU_AND);
          F_OR:    alucontrol = ACW'(ALU_OR);
          F_SLT:   alucontrol = ACW'(ALU_SLT);
          default: alucontrol = ACW'(ALU_ADD);
        endcase
      end
      default: alucontrol = ACW'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM for the multicycle MIPS datapath with memory-ready stalls.
// Define MULTICYCLE_BNE_EN to add the BNE state (code 12).
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int ACW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           iord,
  output logic           irwrite,
  output logic           pcen,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           memwrite,
  output logic           mem_req,
  output logic [ACW-1:0] alucontrol,
  output logic [3:0]     state
);

  logic [3:0] state_q, state_d;
  logic       irw, rw, mw, mreq;
  logic       pcwrite, branch, bne;
  aluop_t     aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    irw      = 1'b0;
    rw       = 1'b0;
    mw       = 1'b0;
    mreq     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    aluop    = AOP_ADD;
    case (state_q)
      S_FETCH: begin
        mreq    = 1'b1;
        alusrcb = 2'b01;
        irw     = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mreq = 1'b1;
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
      end
      S_MEMWR: begin
        mreq = 1'b1;
        iord = 1'b1;
        mw   = mem_ready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        rw     = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: rw = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MULTICYCLE_BNE_EN
      S_BNE: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        bne     = 1'b1;
        pcsrc   = 2'b01;
      end
`endif
      default: ;
    endcase
  end

  // Reset masks every enable so an aborted instruction cannot commit.
  assign irwrite  = irw & ~reset;
  assign regwrite = rw & ~reset;
  assign memwrite = mw & ~reset;
  assign mem_req  = mreq & ~reset;
  assign pcen     = (pcwrite | (branch & zero) | (bne & ~zero)) & ~reset;
  assign state    = state_q;

  mc_aludec #(
    .OPW(OPW),
    .ACW(ACW)
  ) u_aludec (
    .aluop     (aluop),
    .funct     (funct),
    .alucontrol(alucontrol)
  );

endmodule
